// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV register window on a cpu bus,
// a small TX FIFO and a registered serial output.
module bus_uart_tx #(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_oe,
  input  logic        n_we,
  output logic        tx
);

  // state | meaning
  // IDLE  | line high, waiting for a FIFO entry
  // START | start bit (tx=0) for latched DIV+1 cycles
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (tx=1)
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] A_DATA = BASE;
  localparam logic [15:0] A_STAT = BASE + 16'd1;
  localparam logic [15:0] A_DIV  = BASE + 16'd2;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    div, div_lat, shreg, cnt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic          ovf, we_seen, rd_seen, tx_nxt;

  logic hit_data, hit_stat, hit_div, hit;
  logic we_first, stat_rd_first;
  logic full, empty, push, pop, tick, busy;
  logic [7:0] rd_data;

  assign hit_data = (a == A_DATA);
  assign hit_stat = (a == A_STAT);
  assign hit_div  = (a == A_DIV);
  assign hit      = hit_data | hit_stat | hit_div;

  assign we_first      = !n_we && hit && !we_seen;
  assign stat_rd_first = !n_oe && hit_stat && !rd_seen;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = we_first && hit_data && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign tick  = (cnt == 8'd0);
  assign busy  = (state != S_IDLE);

  assign rd_data = hit_stat ? {4'b0000, ovf, busy, full, empty} : div;
  assign d = (!n_oe && (hit_stat || hit_div)) ? rd_data : 8'bzzzz_zzzz;

  // Strobe latches: one action per low pulse, re-armed when the strobe is seen high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      we_seen <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      we_seen <= !n_we && (we_seen || hit);
      rd_seen <= !n_oe && (rd_seen || hit_stat);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div <= 8'h00;
      ovf <= 1'b0;
    end else begin
      if (we_first && hit_div) div <= d;
      if (we_first && hit_data && full) ovf <= 1'b1;
      else if (stat_rd_first)           ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA:  if (tick && bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bit_nxt = (state == S_DATA && tick) ? bit_cnt + 3'd1 : bit_cnt;
    tx_nxt  = 1'b1;
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shreg[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  // Bit timer reloads from the frame's latched divider so mid-frame DIV writes wait a frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx      <= 1'b1;
      cnt     <= 8'h00;
      bit_cnt <= 3'd0;
      div_lat <= 8'h00;
      shreg   <= 8'h00;
    end else begin
      tx <= tx_nxt;
      if (pop) begin
        shreg   <= mem[rd_ptr];
        div_lat <= div;
        cnt     <= div;
      end else if (tick) begin
        cnt <= div_lat;
      end else begin
        cnt <= cnt - 8'd1;
      end
      if (state == S_DATA && tick) bit_cnt <= bit_cnt + 3'd1;
      else if (state != S_DATA)    bit_cnt <= 3'd0;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: register vectors, timed corner sequences and random traffic
// checked by a line-level UART receiver model.
module tb_bus_uart_tx;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_DATA = BASE;
  localparam logic [15:0] A_STAT = BASE + 16'd1;
  localparam logic [15:0] A_DIV  = BASE + 16'd2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        n_oe = 1'b1;
  logic        n_we = 1'b1;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = 8'h00;
  wire  [7:0]  d;
  logic        tx;

  assign d = drv_en ? drv_val : 8'bzzzz_zzzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (d[i]);
  end

  bus_uart_tx #(.BASE(BASE), .DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .a(a), .d(d), .n_oe(n_oe), .n_we(n_we), .tx(tx)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int period = 1;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] val);
    @(negedge clk);
    a = addr; drv_val = val; drv_en = 1'b1; n_we = 1'b0;
    @(negedge clk);
    n_we = 1'b1; drv_en = 1'b0; a = 16'h0000;
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [7:0] val);
    @(negedge clk);
    a = addr; n_oe = 1'b0;
    #1 val = d;
    @(negedge clk);
    n_oe = 1'b1; a = 16'h0000;
  endtask

  task automatic send(input logic [7:0] val);
    exp_q.push_back(val);
    bus_wr(A_DATA, val);
  endtask

  task automatic set_div(input logic [7:0] v);
    bus_wr(A_DIV, v);
    period = int'(v) + 1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (12 * period + 4) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Receiver model: every bit must be stable for a full period; start low, stop high.
  initial begin : rx
    logic [7:0] got, exp;
    bit bad, aborted;
    int p, bp;
    forever begin
      @(negedge clk);
      if (n_rst && tx === 1'b0) begin
        got = 8'h00; bad = 0; aborted = 0; p = period;
        start_cyc.push_back(cyc);
        for (int k = 1; k < 10 * p; k++) begin
          @(negedge clk);
          if (!n_rst) begin
            aborted = 1;
            break;
          end
          bp = k / p;
          if (bp == 0) begin
            if (tx !== 1'b0) bad = 1;
          end else if (bp == 9) begin
            if (tx !== 1'b1) bad = 1;
          end else if (k % p == 0) begin
            got[bp-1] = tx;
          end else if (tx !== got[bp-1]) begin
            bad = 1;
          end
        end
        if (!aborted) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_frame: got unexpected byte %h (framing_bad=%0d)", got, bad);
          end else begin
            exp = exp_q.pop_front();
            if (bad || got !== exp) begin
              errors++;
              $display("FAIL rx_frame: got %h (framing_bad=%0d) expected %h", got, bad, exp);
            end
          end
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0] rv;
    int n0, lows;

    tbl[0]  = '{0, A_STAT, 8'h01};
    tbl[1]  = '{0, A_DIV,  8'h00};
    tbl[2]  = '{1, A_DIV,  8'h5A};
    tbl[3]  = '{0, A_DIV,  8'h5A};
    tbl[4]  = '{0, A_DATA, 8'hFF};
    tbl[5]  = '{0, BASE + 16'd3, 8'hFF};
    tbl[6]  = '{1, BASE + 16'd3, 8'h77};
    tbl[7]  = '{0, A_DIV,  8'h5A};
    tbl[8]  = '{0, A_STAT, 8'h01};
    tbl[9]  = '{0, BASE - 16'd1, 8'hFF};
    tbl[10] = '{1, A_DIV,  8'h03};
    tbl[11] = '{0, A_DIV,  8'h03};

    repeat (3) @(negedge clk);
    check("tx_in_reset", tx, 1'b1);
    n_rst = 1'b1;
    @(negedge clk);
    check("tx_after_reset", tx, 1'b1);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
      else begin
        bus_rd(tbl[i].addr, rv);
        check($sformatf("vec%0d", i), rv, tbl[i].data);
      end
    end
    period = 4;

    // Single frame, DIV=3: start bit appears one edge after the write.
    send(8'hA5);
    check("a5_pre_start", tx, 1'b1);
    @(negedge clk);
    check("a5_start", tx, 1'b0);
    wait_drain("a5_drain");
    bus_rd(A_STAT, rv);
    check("a5_status", rv, 8'h01);

    // Back-to-back frames at DIV=0 with overflow on a full FIFO.
    set_div(8'h00);
    n0 = start_cyc.size();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    bus_wr(A_DATA, 8'h66);
    bus_rd(A_STAT, rv);
    check("ovf_full_bit", rv[1], 1'b1);
    check("ovf_set", rv[3], 1'b1);
    bus_rd(A_STAT, rv);
    check("ovf_cleared", rv[3], 1'b0);
    wait_drain("b2b_drain");
    check("b2b_frames", start_cyc.size() - n0, 5);
    for (int i = n0; i + 1 < start_cyc.size() && i < n0 + 4; i++)
      check($sformatf("b2b_gap%0d", i - n0), start_cyc[i+1] - start_cyc[i], 11);

    // Long write strobe pushes once.
    n0 = start_cyc.size();
    exp_q.push_back(8'h3C);
    @(negedge clk);
    a = A_DATA; drv_val = 8'h3C; drv_en = 1'b1; n_we = 1'b0;
    repeat (5) @(negedge clk);
    n_we = 1'b1; drv_en = 1'b0; a = 16'h0000;
    wait_drain("long_we_drain");
    check("long_we_frames", start_cyc.size() - n0, 1);
    bus_rd(A_STAT, rv);
    check("long_we_status", rv, 8'h01);

    // Reset during data bit 3 aborts the frame.
    set_div(8'h03);
    send(8'h96);
    repeat (18) @(negedge clk);
    check("rst_mid_bit3", tx, 1'b0);
    #2 n_rst = 1'b0;
    #1 check("rst_tx_async", tx, 1'b1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    period = 1;
    bus_rd(A_STAT, rv);
    check("rst_status", rv, 8'h01);
    bus_rd(A_DIV, rv);
    check("rst_div", rv, 8'h00);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_no_frame", lows, 0);

    // Random traffic with flow control on the full flag.
    for (int r = 0; r < 3; r++) begin
      set_div(8'($urandom_range(0, 3)));
      for (int j = 0; j < 10; j++) begin
        int w;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        w = 0;
        bus_rd(A_STAT, rv);
        while (rv[1] && w < 500) begin
          bus_rd(A_STAT, rv);
          w++;
        end
        if (w >= 500) check("rnd_full_timeout", rv[1], 1'b0);
        send(8'($urandom_range(0, 255)));
      end
      wait_drain($sformatf("rnd%0d_drain", r));
      bus_rd(A_STAT, rv);
      check($sformatf("rnd%0d_status", r), rv, 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
Parameters:
REQ-001 SHALL have parameter BASE, default 16'hFF00, giving the base address of the 3-byte register window.
REQ-002 SHALL have parameter DEPTH, default 4, giving the TX FIFO entry count (power of two, >=2).
Ports:
REQ-003 SHALL have port clk  input  1  system clock, the same clock that drives the cpu; all state changes on the rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a  input  16  cpu address bus.
REQ-006 SHALL have port d  inout  8  cpu data bus; driven only during a register read, high-Z otherwise.
REQ-007 SHALL have port n_oe  input  1  cpu read strobe, active-low.
REQ-008 SHALL have port n_we  input  1  cpu write strobe, active-low.
REQ-009 SHALL have port tx  output  1  serial line, 8N1, idle high.

Function
REQ-010 SHALL decode three registers: BASE+0 DATA (write only), BASE+1 STATUS (read only), BASE+2 DIV (read/write); all other addresses are ignored.
REQ-011 SHALL drive d combinationally when n_oe=0 and a hits STATUS or DIV, and drive 8'hzz otherwise, including on a DATA read.
REQ-012 SHALL report STATUS bits as: bit0 FIFO empty, bit1 FIFO full, bit2 transmitter busy (state != IDLE), bit3 overflow sticky, bits7:4 zero.
REQ-013 SHALL clear overflow on the rising edge that completes a STATUS read (first edge with n_oe=0 and a STATUS hit).
REQ-014 SHALL accept exactly one write per n_we low pulse: the first rising edge with n_we=0 and an address hit performs the write; later edges are ignored until a rising edge samples n_we=1.
REQ-015 SHALL push d into the FIFO on a DATA write when not full.
REQ-016 SHALL drop a DATA write when full, leaving the FIFO unchanged and setting overflow, even if a pop occurs on the same edge.
REQ-017 SHALL load DIV from d on a DIV write; bit period = DIV+1 clk cycles.
REQ-018 SHALL implement TX state machine IDLE -> START -> DATA -> STOP -> IDLE.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop the head on the next edge, latch the byte and DIV, and enter START with tx=0.
REQ-020 SHALL hold each START, DATA and STOP bit for latched DIV+1 cycles; DIV writes mid-frame take effect at the next frame.
REQ-021 SHALL send DATA bits LSB first (8 bits, 3-bit bit counter), with tx=1 during STOP.
REQ-022 SHALL, after STOP, go to IDLE and start the next frame on the following edge if the FIFO is non-empty, giving exactly one idle cycle between back-to-back frames.
REQ-023 SHALL allow a push and a pop on the same edge when neither full nor empty, leaving the occupancy count unchanged.
REQ-024 SHALL wrap the FIFO read and write pointers modulo DEPTH and track occupancy 0..DEPTH.
REQ-025 SHALL register tx (no combinational path from inputs to tx).

Reset
REQ-026 SHALL, while n_rst=0, immediately force: tx=1, state IDLE, FIFO empty, both pointers 0, overflow 0, DIV 8'h00, and the write-pulse latch cleared.
REQ-027 SHALL abort a frame when reset is asserted mid-frame, with tx returning high asynchronously and the aborted and queued bytes discarded.
REQ-028 SHALL resume normal operation on the first rising edge after n_rst deasserts.

Verification
REQ-029 SHALL pass: reset, read STATUS -> 8'h01; read DIV -> 8'h00; tx=1.
REQ-030 SHALL pass: DIV=3, write DATA 8'hA5 -> tx low 1 edge after the write, then bits 1,0,1,0,0,1,0,1, then stop high, each bit 4 cycles, 40 cycles total; STATUS returns to 8'h01.
REQ-031 SHALL pass: DIV=0, 5 back-to-back DATA writes while the first is transmitting -> 5th accepted once a slot frees (4 queued + 1 in flight); a 6th write with FIFO full sets STATUS bit3, and the next STATUS read returns bit3=1, with the following read returning bit3=0.
REQ-032 SHALL pass: n_we held low for 5 cycles on a DATA hit -> exactly one push.
REQ-033 SHALL pass: reset pulse during DATA bit 3 -> tx=1 within the reset, STATUS 8'h01 after release, and no further frame.
REQ-034 SHALL pass: n_oe=0 at BASE+0 or at BASE+3 -> d high-Z; write at BASE+3 -> no state change.
